// File: rtl/matrix_pkg.sv
// Shared definitions for the 2x2 matrix loader and multiplier:
// loader states, operand layout and datapath widths.
package matrix_pkg;

    localparam int MAT_ELEMS = 8;
    localparam int OP_W      = 8;
    localparam int RES_W     = 16;

    localparam logic [2:0] IDX_A11 = 3'd0;
    localparam logic [2:0] IDX_A12 = 3'd1;
    localparam logic [2:0] IDX_A21 = 3'd2;
    localparam logic [2:0] IDX_A22 = 3'd3;
    localparam logic [2:0] IDX_B11 = 3'd4;
    localparam logic [2:0] IDX_B12 = 3'd5;
    localparam logic [2:0] IDX_B21 = 3'd6;
    localparam logic [2:0] IDX_B22 = 3'd7;

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        COLLECT    = 2'd1,
        ISSUE      = 2'd2,
        WAIT       = 2'd3
    } loader_state_t;

endpackage

// File: rtl/matrix_loader.sv
// Collects an 8-byte framed stream into 2x2 operand registers, fires a
// one-cycle start to the multiplier and holds operands until done or timeout.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    input  logic [OP_W-1:0] s_data,
    input  logic            s_last,
    output logic            s_ready,
    input  logic            done,
    output logic            start,
    output logic [OP_W-1:0] A11,
    output logic [OP_W-1:0] A12,
    output logic [OP_W-1:0] A21,
    output logic [OP_W-1:0] A22,
    output logic [OP_W-1:0] B11,
    output logic [OP_W-1:0] B12,
    output logic [OP_W-1:0] B21,
    output logic [OP_W-1:0] B22,
    output logic            busy,
    output logic            err_frame,
    output logic            err_timeout,
    output logic [7:0]      frame_cnt
);

    loader_state_t   state_r;
    loader_state_t   state_nxt_s;
    logic [2:0]      idx_r;
    logic [7:0]      tmo_r;
    logic [OP_W-1:0] ops_r [MAT_ELEMS];
    logic            s_ready_r;
    logic            start_r;
    logic            busy_r;
    logic            err_frame_r;
    logic            err_timeout_r;
    logic [7:0]      frame_cnt_r;

    logic            accept_s;
    logic            frame_ok_s;
    logic            frame_err_s;
    logic            done_hit_s;
    logic            tmo_hit_s;

    // Next-state and framing decisions
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        frame_ok_s  = 1'b0;
        frame_err_s = 1'b0;
        done_hit_s  = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            RESET_IDLE: begin
                state_nxt_s = COLLECT;
            end
            COLLECT: begin
                accept_s = s_valid && s_ready_r;
                if (accept_s && s_last && (idx_r == IDX_B22)) begin
                    frame_ok_s  = 1'b1;
                    state_nxt_s = ISSUE;
                end else if (accept_s && (s_last || (idx_r == IDX_B22))) begin
                    frame_err_s = 1'b1;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                // done takes priority over an expiring timeout
                if (done) begin
                    done_hit_s  = 1'b1;
                    state_nxt_s = COLLECT;
                end else if (tmo_r == 8'd0) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = RESET_IDLE;
            end
        endcase
    end

    // State, registered handshake/status outputs, operands and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= RESET_IDLE;
            idx_r         <= 3'd0;
            tmo_r         <= 8'd0;
            s_ready_r     <= 1'b0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            err_frame_r   <= 1'b0;
            err_timeout_r <= 1'b0;
            frame_cnt_r   <= 8'd0;
            for (int i = 0; i < MAT_ELEMS; i++) begin
                ops_r[i] <= '0;
            end
        end else begin
            state_r       <= state_nxt_s;
            s_ready_r     <= (state_nxt_s == COLLECT) && (state_r != RESET_IDLE);
            start_r       <= (state_nxt_s == ISSUE);
            busy_r        <= (state_nxt_s == ISSUE) || (state_nxt_s == WAIT);
            err_frame_r   <= frame_err_s;
            err_timeout_r <= tmo_hit_s;

            if (accept_s) begin
                ops_r[idx_r] <= s_data;
                if (frame_ok_s || frame_err_s) begin
                    idx_r <= 3'd0;
                end else begin
                    idx_r <= idx_r + 3'd1;
                end
            end

            if (done_hit_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end

            // Down-counter armed in ISSUE so WAIT lasts exactly TIMEOUT cycles
            if (state_r == ISSUE) begin
                tmo_r <= 8'(TIMEOUT - 1);
            end else if ((state_r == WAIT) && (tmo_r != 8'd0)) begin
                tmo_r <= tmo_r - 8'd1;
            end
        end
    end

    assign s_ready     = s_ready_r;
    assign start       = start_r;
    assign busy        = busy_r;
    assign err_frame   = err_frame_r;
    assign err_timeout = err_timeout_r;
    assign frame_cnt   = frame_cnt_r;

    assign A11 = ops_r[IDX_A11];
    assign A12 = ops_r[IDX_A12];
    assign A21 = ops_r[IDX_A21];
    assign A22 = ops_r[IDX_A22];
    assign B11 = ops_r[IDX_B11];
    assign B12 = ops_r[IDX_B12];
    assign B21 = ops_r[IDX_B21];
    assign B22 = ops_r[IDX_B22];

endmodule
